// File: rtl/dpram_port_arbiter_if.sv
// dpram_port_arbiter_if
// Bundles the requester-side handshake and the single RAM port that the
// arbiter shares between them.
//   master modport : requesters plus RAM (drive hold/req/we/addr/wdata/ram_q)
//   slave modport  : the arbiter (drives ack/rvalid/rdata/ram_wren/ram_address/ram_data)
// Signals:
//   hold        - block new grants while high
//   req/we      - per-requester request and write flag (held until ack)
//   addr/wdata  - flattened per-requester address / write data, slice i = requester i
//   ack/rvalid  - one-hot single-cycle pulses: request accepted / read data valid
//   rdata       - read data shared by all requesters
//   ram_*       - connection to one port of the dual-port RAM
interface dpram_port_arbiter_if #(
    parameter int address_width = 10,
    parameter int data_width    = 8,
    parameter int num_req       = 3
);
    logic                             hold;
    logic [num_req-1:0]               req;
    logic [num_req-1:0]               we;
    logic [num_req*address_width-1:0] addr;
    logic [num_req*data_width-1:0]    wdata;
    logic [num_req-1:0]               ack;
    logic [num_req-1:0]               rvalid;
    logic [data_width-1:0]            rdata;
    logic                             ram_wren;
    logic [address_width-1:0]         ram_address;
    logic [data_width-1:0]            ram_data;
    logic [data_width-1:0]            ram_q;

    modport master (
        output hold, req, we, addr, wdata, ram_q,
        input  ack, rvalid, rdata, ram_wren, ram_address, ram_data
    );

    modport slave (
        input  hold, req, we, addr, wdata, ram_q,
        output ack, rvalid, rdata, ram_wren, ram_address, ram_data
    );
endinterface

// File: rtl/dpram_port_arbiter.sv
// dpram_port_arbiter
// Shares one port of a dual-port RAM (1-cycle registered read) between
// num_req requesters. Round-robin arbitration, optionally with requester 0
// given absolute priority (pri0=1). One RAM access per clock; read data is
// returned on rdata with a one-hot rvalid naming the requester.
// Ports:
//   clock   - clock shared with the RAM port
//   reset_n - asynchronous active-low reset
//   bus     - dpram_port_arbiter_if.slave (requester handshake + RAM port)
module dpram_port_arbiter #(
    parameter int address_width = 10,
    parameter int data_width    = 8,
    parameter int num_req       = 3,
    parameter int pri0          = 0
) (
    input  logic                clock,
    input  logic                reset_n,
    dpram_port_arbiter_if.slave bus
);
    localparam int               idx_w    = (num_req > 1) ? $clog2(num_req) : 1;
    localparam bit               pri0_en  = (pri0 != 0);
    localparam logic [idx_w-1:0] last_rst = idx_w'(num_req - 1);
    localparam logic [num_req-1:0] one_hot0 = {{(num_req-1){1'b0}}, 1'b1};

    logic [num_req-1:0]       ack_r;
    logic [num_req-1:0]       rvalid_r;
    logic                     ram_wren_r;
    logic [address_width-1:0] ram_address_r;
    logic [data_width-1:0]    ram_data_r;
    logic [idx_w-1:0]         last_r;

    logic [num_req-1:0]       elig_s;
    logic                     rr_found_s;
    logic [idx_w-1:0]         rr_idx_s;
    logic                     grant_s;
    logic [idx_w-1:0]         win_s;
    logic                     sel_we_s;
    logic [address_width-1:0] sel_addr_s;
    logic [data_width-1:0]    sel_data_s;

    // First eligible requester after 'last', wrapping; index 0 is left out of
    // the rotation when it already has fixed priority. Iterating from the
    // farthest candidate down lets the nearest one overwrite the result.
    function automatic logic [idx_w:0] rr_pick(input logic [num_req-1:0] elig,
                                               input logic [idx_w-1:0]   last);
        logic [idx_w:0] res;
        int             idx;
        res = '0;
        for (int k = num_req; k >= 1; k--) begin
            idx = int'(last) + k;
            if (idx >= num_req) begin
                idx = idx - num_req;
            end
            if (elig[idx_w'(idx)] && !(pri0_en && (idx == 0))) begin
                res = {1'b1, idx_w'(idx)};
            end
        end
        return res;
    endfunction

    // A request whose ack is high this cycle is completing its handshake and
    // must not be granted again on the same edge.
    assign elig_s = bus.req & ~ack_r;

    // Winner selection and operand multiplexing for the next edge
    always_comb begin
        {rr_found_s, rr_idx_s} = rr_pick(elig_s, last_r);
        if (bus.hold) begin
            grant_s = 1'b0;
            win_s   = '0;
        end else if (pri0_en && elig_s[0]) begin
            grant_s = 1'b1;
            win_s   = '0;
        end else begin
            grant_s = rr_found_s;
            win_s   = rr_idx_s;
        end
        sel_we_s   = bus.we[win_s];
        sel_addr_s = bus.addr[int'(win_s) * address_width +: address_width];
        sel_data_s = bus.wdata[int'(win_s) * data_width +: data_width];
    end

    // Grant registers, round-robin pointer and read-return pulse
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ack_r         <= '0;
            rvalid_r      <= '0;
            ram_wren_r    <= 1'b0;
            ram_address_r <= '0;
            ram_data_r    <= '0;
            last_r        <= last_rst;
        end else begin
            // The RAM samples the address granted last edge now, so its data
            // appears on ram_q for the cycle that follows; writes never return.
            rvalid_r <= ack_r & {num_req{~ram_wren_r}};
            if (grant_s) begin
                ack_r         <= one_hot0 << win_s;
                ram_wren_r    <= sel_we_s;
                ram_address_r <= sel_addr_s;
                ram_data_r    <= sel_data_s;
                // A priority win by requester 0 leaves the rotation untouched.
                if (!(pri0_en && (win_s == '0))) begin
                    last_r <= win_s;
                end else begin
                    last_r <= last_r;
                end
            end else begin
                ack_r      <= '0;
                ram_wren_r <= 1'b0;
            end
        end
    end

    assign bus.ack         = ack_r;
    assign bus.rvalid      = rvalid_r;
    assign bus.ram_wren    = ram_wren_r;
    assign bus.ram_address = ram_address_r;
    assign bus.ram_data    = ram_data_r;
    assign bus.rdata       = bus.ram_q;
endmodule

// File: tb/tb_dpram_port_arbiter.sv
// tb_dpram_port_arbiter
// Two arbiters (pri0=0 and pri0=1) each with their own behavioural RAM,
// checked every cycle against a reference model that tracks grants, the
// round-robin position and a shadow copy of RAM contents.
module tb_dpram_port_arbiter;
    localparam int aw = 10;
    localparam int dw = 8;
    localparam int nr = 3;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    logic hold    = 1'b0;
    always #5 clock = ~clock;

    logic [nr-1:0]    req_v   [2];
    logic [nr-1:0]    we_v    [2];
    logic [nr*aw-1:0] addr_v  [2];
    logic [nr*dw-1:0] wdata_v [2];
    logic [dw-1:0]    q_v     [2];

    logic [nr-1:0] o_ack    [2];
    logic [nr-1:0] o_rvalid [2];
    logic          o_wren   [2];
    logic [aw-1:0] o_addr   [2];
    logic [dw-1:0] o_data   [2];
    logic [dw-1:0] o_rdata  [2];

    dpram_port_arbiter_if #(.address_width(aw), .data_width(dw), .num_req(nr)) bus0 ();
    dpram_port_arbiter_if #(.address_width(aw), .data_width(dw), .num_req(nr)) bus1 ();

    assign bus0.hold  = hold;       assign bus1.hold  = hold;
    assign bus0.req   = req_v[0];   assign bus1.req   = req_v[1];
    assign bus0.we    = we_v[0];    assign bus1.we    = we_v[1];
    assign bus0.addr  = addr_v[0];  assign bus1.addr  = addr_v[1];
    assign bus0.wdata = wdata_v[0]; assign bus1.wdata = wdata_v[1];
    assign bus0.ram_q = q_v[0];     assign bus1.ram_q = q_v[1];

    assign o_ack[0]    = bus0.ack;         assign o_ack[1]    = bus1.ack;
    assign o_rvalid[0] = bus0.rvalid;      assign o_rvalid[1] = bus1.rvalid;
    assign o_wren[0]   = bus0.ram_wren;    assign o_wren[1]   = bus1.ram_wren;
    assign o_addr[0]   = bus0.ram_address; assign o_addr[1]   = bus1.ram_address;
    assign o_data[0]   = bus0.ram_data;    assign o_data[1]   = bus1.ram_data;
    assign o_rdata[0]  = bus0.rdata;       assign o_rdata[1]  = bus1.rdata;

    dpram_port_arbiter #(.address_width(aw), .data_width(dw), .num_req(nr), .pri0(0)) dut0 (
        .clock(clock), .reset_n(reset_n), .bus(bus0.slave));
    dpram_port_arbiter #(.address_width(aw), .data_width(dw), .num_req(nr), .pri0(1)) dut1 (
        .clock(clock), .reset_n(reset_n), .bus(bus1.slave));

    function automatic logic [dw-1:0] init_val(input int a);
        logic [31:0] t;
        t = a;
        return t[7:0] ^ 8'hF2;
    endfunction

    // Behavioural RAMs: registered read, write at the clock edge
    logic [dw-1:0] mem [2][1024];
    logic          mem_ready = 1'b0;
    always @(posedge clock) begin
        if (!mem_ready) begin
            for (int a = 0; a < 1024; a++) begin
                mem[0][a] = init_val(a);
                mem[1][a] = init_val(a);
            end
            mem_ready = 1'b1;
        end
        for (int d = 0; d < 2; d++) begin
            q_v[d] = mem[d][o_addr[d]];
            if (o_wren[d]) mem[d][o_addr[d]] = o_data[d];
        end
    end

    // Reference model state
    logic [dw-1:0] shd       [2][1024];
    logic [nr-1:0] e_ack     [2];
    logic [nr-1:0] e_rvalid  [2];
    logic          e_wren    [2];
    logic [aw-1:0] e_addr    [2];
    logic [dw-1:0] e_data    [2];
    logic [dw-1:0] e_rdata   [2];
    int            m_last    [2];
    int            m_rd_idx  [2];
    logic [dw-1:0] m_rd_data [2];
    logic          m_wr_pend [2];
    logic [aw-1:0] m_wr_addr [2];
    logic [dw-1:0] m_wr_data [2];

    int n_vec = 0;
    int n_err = 0;

    logic [nr-1:0] pat0 [6];
    logic [nr-1:0] pat1 [6];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset(input int d);
        e_ack[d] = '0; e_rvalid[d] = '0; e_wren[d] = 1'b0;
        e_addr[d] = '0; e_data[d] = '0; e_rdata[d] = '0;
        m_last[d] = nr - 1; m_rd_idx[d] = -1; m_wr_pend[d] = 1'b0;
    endtask

    // Predict what the arbiter shows after the coming edge
    task automatic model_edge(input int d);
        logic [nr-1:0] elig;
        int w;
        int i;
        bit pri;
        pri = (d == 1);
        if (m_wr_pend[d]) begin
            shd[d][m_wr_addr[d]] = m_wr_data[d];
            m_wr_pend[d] = 1'b0;
        end
        e_rvalid[d] = '0;
        if (m_rd_idx[d] >= 0) begin
            e_rvalid[d][m_rd_idx[d]] = 1'b1;
            e_rdata[d] = m_rd_data[d];
        end
        m_rd_idx[d] = -1;
        elig = req_v[d] & ~e_ack[d];
        w = -1;
        if (!hold) begin
            if (pri && elig[0]) w = 0;
            else begin
                for (int k = 1; k <= nr; k++) begin
                    i = (m_last[d] + k) % nr;
                    if (w < 0 && elig[i] && !(pri && i == 0)) w = i;
                end
            end
        end
        e_ack[d]  = '0;
        e_wren[d] = 1'b0;
        if (w >= 0) begin
            e_ack[d][w] = 1'b1;
            e_wren[d]   = we_v[d][w];
            e_addr[d]   = addr_v[d][w*aw +: aw];
            e_data[d]   = wdata_v[d][w*dw +: dw];
            if (!(pri && w == 0)) m_last[d] = w;
            if (e_wren[d]) begin
                m_wr_pend[d] = 1'b1;
                m_wr_addr[d] = e_addr[d];
                m_wr_data[d] = e_data[d];
            end else begin
                m_rd_idx[d]  = w;
                m_rd_data[d] = shd[d][e_addr[d]];
            end
        end
    endtask

    task automatic check_outputs(input int d);
        check_eq($sformatf("d%0d ack", d), 32'(o_ack[d]), 32'(e_ack[d]));
        check_eq($sformatf("d%0d rvalid", d), 32'(o_rvalid[d]), 32'(e_rvalid[d]));
        check_eq($sformatf("d%0d ram_wren", d), 32'(o_wren[d]), 32'(e_wren[d]));
        check_eq($sformatf("d%0d ram_address", d), 32'(o_addr[d]), 32'(e_addr[d]));
        check_eq($sformatf("d%0d ram_data", d), 32'(o_data[d]), 32'(e_data[d]));
        if (e_rvalid[d] != '0)
            check_eq($sformatf("d%0d rdata", d), 32'(o_rdata[d]), 32'(e_rdata[d]));
    endtask

    // mode 0: drop req on ack, 1: hold req, 2: random requesters
    task automatic cycle(input int mode);
        model_edge(0);
        model_edge(1);
        @(posedge clock);
        #1;
        check_outputs(0);
        check_outputs(1);
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < nr; i++) begin
                if (mode == 0) begin
                    if (e_ack[d][i]) req_v[d][i] = 1'b0;
                end else if (mode == 2) begin
                    if (!req_v[d][i] || e_ack[d][i]) begin
                        if ($urandom_range(0, 2) != 0) begin
                            req_v[d][i] = 1'b1;
                            we_v[d][i]  = 1'($urandom_range(0, 1));
                            addr_v[d][i*aw +: aw]  = aw'($urandom_range(0, 15));
                            wdata_v[d][i*dw +: dw] = dw'($urandom);
                        end else begin
                            req_v[d][i] = 1'b0;
                        end
                    end
                end
            end
        end
        if (mode == 2) hold = ($urandom_range(0, 7) == 0);
    endtask

    task automatic set_all(input logic [nr-1:0] r, input logic [nr-1:0] w);
        for (int d = 0; d < 2; d++) begin
            req_v[d] = r;
            we_v[d]  = w;
        end
    endtask

    task automatic set_slot(input int i, input logic [aw-1:0] a, input logic [dw-1:0] wd);
        for (int d = 0; d < 2; d++) begin
            addr_v[d][i*aw +: aw]  = a;
            wdata_v[d][i*dw +: dw] = wd;
        end
    endtask

    // Asynchronous reset pulse asserted away from the clock edge
    task automatic do_reset();
        #2 reset_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            check_eq($sformatf("d%0d rst ack", d), 32'(o_ack[d]), 32'd0);
            check_eq($sformatf("d%0d rst rvalid", d), 32'(o_rvalid[d]), 32'd0);
            check_eq($sformatf("d%0d rst wren", d), 32'(o_wren[d]), 32'd0);
            check_eq($sformatf("d%0d rst addr", d), 32'(o_addr[d]), 32'd0);
            check_eq($sformatf("d%0d rst data", d), 32'(o_data[d]), 32'd0);
            model_reset(d);
        end
        set_all(3'b000, 3'b000);
        @(negedge clock);
        @(posedge clock);
        #1;
        for (int d = 0; d < 2; d++) begin
            check_eq($sformatf("d%0d in-rst rvalid", d), 32'(o_rvalid[d]), 32'd0);
            check_eq($sformatf("d%0d in-rst wren", d), 32'(o_wren[d]), 32'd0);
        end
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        pat0 = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        pat1 = '{3'b001, 3'b010, 3'b001, 3'b100, 3'b001, 3'b010};
        for (int d = 0; d < 2; d++) begin
            req_v[d] = '0; we_v[d] = '0; addr_v[d] = '0; wdata_v[d] = '0;
            model_reset(d);
            for (int a = 0; a < 1024; a++) shd[d][a] = init_val(a);
        end

        // Reset values
        repeat (2) @(posedge clock);
        #1;
        for (int d = 0; d < 2; d++) begin
            check_eq($sformatf("d%0d init ack", d), 32'(o_ack[d]), 32'd0);
            check_eq($sformatf("d%0d init rvalid", d), 32'(o_rvalid[d]), 32'd0);
            check_eq($sformatf("d%0d init wren", d), 32'(o_wren[d]), 32'd0);
            check_eq($sformatf("d%0d init addr", d), 32'(o_addr[d]), 32'd0);
            check_eq($sformatf("d%0d init data", d), 32'(o_data[d]), 32'd0);
        end
        @(negedge clock);
        reset_n = 1'b1;

        // hold blocks grants; release gives requester 0 then 1
        hold = 1'b1;
        set_all(3'b011, 3'b000);
        set_slot(0, 10'h011, 8'h00);
        set_slot(1, 10'h012, 8'h00);
        repeat (4) begin
            cycle(0);
            for (int d = 0; d < 2; d++) begin
                check_eq($sformatf("d%0d hold ack", d), 32'(o_ack[d]), 32'd0);
                check_eq($sformatf("d%0d hold wren", d), 32'(o_wren[d]), 32'd0);
            end
        end
        hold = 1'b0;
        cycle(0);
        for (int d = 0; d < 2; d++) check_eq($sformatf("d%0d unhold ack0", d), 32'(o_ack[d]), 32'd1);
        cycle(0);
        for (int d = 0; d < 2; d++) check_eq($sformatf("d%0d unhold ack1", d), 32'(o_ack[d]), 32'd2);
        repeat (2) cycle(0);

        // Reset right after a read ack drops the pending rvalid
        set_all(3'b001, 3'b000);
        set_slot(0, 10'h020, 8'h00);
        cycle(0);
        for (int d = 0; d < 2; d++) check_eq($sformatf("d%0d pre-rst ack", d), 32'(o_ack[d]), 32'd1);
        do_reset();
        set_all(3'b111, 3'b000);
        cycle(0);
        for (int d = 0; d < 2; d++) check_eq($sformatf("d%0d post-rst ack", d), 32'(o_ack[d]), 32'd1);
        repeat (4) cycle(0);

        // Continuous requests from all three
        do_reset();
        set_all(3'b111, 3'b000);
        set_slot(0, 10'h030, 8'h00);
        set_slot(1, 10'h031, 8'h00);
        set_slot(2, 10'h032, 8'h00);
        for (int c = 0; c < 6; c++) begin
            cycle(1);
            check_eq($sformatf("rr ack c%0d", c), 32'(o_ack[0]), 32'(pat0[c]));
            check_eq($sformatf("pri0 ack c%0d", c), 32'(o_ack[1]), 32'(pat1[c]));
        end
        set_all(3'b000, 3'b000);
        repeat (2) cycle(0);

        // Single read by requester 1
        set_all(3'b010, 3'b000);
        set_slot(1, 10'h055, 8'h00);
        cycle(0);
        for (int d = 0; d < 2; d++) check_eq($sformatf("d%0d sr ack", d), 32'(o_ack[d]), 32'd2);
        cycle(0);
        for (int d = 0; d < 2; d++) begin
            check_eq($sformatf("d%0d sr rvalid", d), 32'(o_rvalid[d]), 32'd2);
            check_eq($sformatf("d%0d sr rdata", d), 32'(o_rdata[d]), 32'hA7);
        end
        cycle(0);
        for (int d = 0; d < 2; d++) check_eq($sformatf("d%0d sr rvalid off", d), 32'(o_rvalid[d]), 32'd0);

        // Write by requester 2, then read back by requester 0
        set_all(3'b100, 3'b100);
        set_slot(2, 10'h100, 8'h3C);
        cycle(0);
        for (int d = 0; d < 2; d++) check_eq($sformatf("d%0d wr wren", d), 32'(o_wren[d]), 32'd1);
        set_slot(0, 10'h100, 8'h00);
        for (int d = 0; d < 2; d++) req_v[d][0] = 1'b1;
        cycle(0);
        for (int d = 0; d < 2; d++) begin
            check_eq($sformatf("d%0d wr no rvalid", d), 32'(o_rvalid[d]), 32'd0);
            check_eq($sformatf("d%0d rd ack", d), 32'(o_ack[d]), 32'd1);
        end
        cycle(0);
        for (int d = 0; d < 2; d++) begin
            check_eq($sformatf("d%0d rd rvalid", d), 32'(o_rvalid[d]), 32'd1);
            check_eq($sformatf("d%0d rd rdata", d), 32'(o_rdata[d]), 32'h3C);
        end
        cycle(0);

        // Randomised traffic
        repeat (1500) cycle(2);
        hold = 1'b0;
        set_all(3'b000, 3'b000);
        repeat (3) cycle(0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
